lane_queue_encoder: RTL and testbench

Sensor front-end for the 4-way traffic light controller: it drives the controller's per-road queue-density inputs (a1–a3, b1–b3, c1–c3, d1–d3) and emergency inputs (ss1–ss4). It tracks a saturating vehicle count per road from arrival and departure detector pulses, encodes each count as a 3-bit thermometer level, and arbitrates emergency-vehicle requests into one held ssN pulse at a time. Roads a, b, c and d map to index 0, 1, 2 and 3.

---
 rtl/lane_queue_encoder_if.sv | 25 ++
 rtl/lane_queue_encoder.sv | 132 +++++++++++++
 tb/tb_lane_queue_encoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_queue_encoder_if.sv
// Sensor-side bus of lane_queue_encoder.
//   arr/dep/emg_req : per-road detector pulses (road a,b,c,d = bit 0..3)
//   a1..d3          : registered thermometer queue levels per road
//   ss1..ss4        : one-hot emergency grant
//   ovf             : sticky per-road counter overflow
//   busy            : grant held or request pending
// slave = encoder side, master = detector/controller side.
interface lane_queue_encoder_if;
  logic [3:0] arr, dep, emg_req;
  logic       a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3;
  logic       ss1, ss2, ss3, ss4;
  logic [3:0] ovf;
  logic       busy;

  modport slave (
    input  arr, dep, emg_req,
    output a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3,
    output ss1, ss2, ss3, ss4, ovf, busy
  );
  modport master (
    output arr, dep, emg_req,
    input  a1, a2, a3, b1, b2, b3, c1, c2, c3, d1, d2, d3,
    input  ss1, ss2, ss3, ss4, ovf, busy
  );
endinterface

// File: rtl/lane_queue_encoder.sv
// lane_queue_encoder: per-road saturating vehicle counters with registered
// thermometer levels, plus an emergency-request arbiter that holds one
// ssN grant at a time for HOLD cycles.
//   clock   : system clock, rising edge
//   clear_n : asynchronous active-low reset
//   bus     : lane_queue_encoder_if.slave (detector inputs, level/grant outputs)

// One road: counter, sticky overflow, thermometer level.
module lqe_lane #(
  parameter int CNT_W = 6,
  parameter int TH1   = 4,
  parameter int TH2   = 8,
  parameter int TH3   = 12
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       arr,
  input  logic       dep,
  output logic [2:0] lvl,
  output logic       ovf
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
      lvl <= '0;
      ovf <= 1'b0;
    end else begin
      // Encoded from the counter register, so the level trails the count
      // by one edge and is thermometer-valid by construction.
      lvl <= {cnt >= CNT_W'(TH3), cnt >= CNT_W'(TH2), cnt >= CNT_W'(TH1)};
      if (arr && !dep) begin
        if (cnt == CMAX) ovf <= 1'b1;
        else             cnt <= cnt + 1'b1;
      end else if (dep && !arr && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

module lane_queue_encoder #(
  parameter int CNT_W = 6,
  parameter int TH1   = 4,
  parameter int TH2   = 8,
  parameter int TH3   = 12,
  parameter int HOLD  = 16
) (
  input  logic                 clock,
  input  logic                 clear_n,
  lane_queue_encoder_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(HOLD - 1);

  logic [NUM_LANES-1:0][2:0] lvl;
  logic [NUM_LANES-1:0]      ovf;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lqe_lane #(.CNT_W(CNT_W), .TH1(TH1), .TH2(TH2), .TH3(TH3)) u_lane (
      .clock   (clock),
      .clear_n (clear_n),
      .arr     (bus.arr[i]),
      .dep     (bus.dep[i]),
      .lvl     (lvl[i]),
      .ovf     (ovf[i])
    );
  end

  // Emergency arbiter
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  state_t               state;
  logic [NUM_LANES-1:0] ss;     // one-hot current grant
  logic [NUM_LANES-1:0] pend;
  logic [TW-1:0]        timer;
  logic [NUM_LANES-1:0] merged, nxt, req_first;

  // v & -v isolates the lowest set bit: lowest index wins.
  assign req_first = bus.emg_req & (~bus.emg_req + 4'd1);
  assign merged    = pend | bus.emg_req;
  assign nxt       = merged & (~merged + 4'd1);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      ss    <= '0;
      pend  <= '0;
      timer <= '0;
    end else begin
      case (state)
        S_IDLE: if (|bus.emg_req) begin
          ss    <= req_first;
          pend  <= pend | (bus.emg_req & ~req_first);
          timer <= RELOAD;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (|(bus.emg_req & ss)) begin
            // Retrigger wins over expiry for the granted road.
            timer <= RELOAD;
            pend  <= pend | (bus.emg_req & ~ss);
          end else if (timer == '0) begin
            if (|merged) begin
              // Hand over on the same edge: no idle cycle between grants.
              ss    <= nxt;
              pend  <= merged & ~nxt;
              timer <= RELOAD;
            end else begin
              ss    <= '0;
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
            pend  <= pend | bus.emg_req;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_HOLD) | (|pend);
  assign bus.ovf  = ovf;
  assign {bus.ss4, bus.ss3, bus.ss2, bus.ss1} = ss;
  assign {bus.a3, bus.a2, bus.a1} = lvl[0];
  assign {bus.b3, bus.b2, bus.b1} = lvl[1];
  assign {bus.c3, bus.c2, bus.c1} = lvl[2];
  assign {bus.d3, bus.d2, bus.d1} = lvl[3];
endmodule

// File: tb/tb_lane_queue_encoder.sv
// Scoreboard bench for lane_queue_encoder: the stimulus process drives
// inputs on the falling edge and pushes the model's expected post-edge
// outputs; the monitor pops and compares after every rising edge.
module tb_lane_queue_encoder;
  localparam int CNT_W = 6, TH1 = 4, TH2 = 8, TH3 = 12, HOLD = 16;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  lane_queue_encoder_if bus();

  lane_queue_encoder #(.CNT_W(CNT_W), .TH1(TH1), .TH2(TH2), .TH3(TH3), .HOLD(HOLD)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0][2:0] lvl;
    logic [3:0]      ss;
    logic [3:0]      ovf;
    logic            busy;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: integer counts, grant as road index + remaining cycles.
  int       cnt_m[4];
  bit [2:0] lvl_m[4];
  bit [3:0] ovf_m;
  int       gnt;     // -1 when nothing granted
  int       rem;     // cycles the current grant still stays high
  bit [3:0] pend_m;

  function automatic int lowest_idx(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.lvl[0] = {bus.a3, bus.a2, bus.a1};
    o.lvl[1] = {bus.b3, bus.b2, bus.b1};
    o.lvl[2] = {bus.c3, bus.c2, bus.c1};
    o.lvl[3] = {bus.d3, bus.d2, bus.d1};
    o.ss     = {bus.ss4, bus.ss3, bus.ss2, bus.ss1};
    o.ovf    = bus.ovf;
    o.busy   = bus.busy;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < 4; i++) o.lvl[i] = lvl_m[i];
    o.ss   = (gnt >= 0) ? (4'b0001 << gnt) : 4'b0000;
    o.ovf  = ovf_m;
    o.busy = (gnt >= 0) || (pend_m != 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin cnt_m[i] = 0; lvl_m[i] = 3'b000; end
    ovf_m = '0; gnt = -1; rem = 0; pend_m = '0;
  endtask

  task automatic model_edge(input bit [3:0] a, input bit [3:0] d, input bit [3:0] e);
    int n;
    for (int i = 0; i < 4; i++) begin
      lvl_m[i] = {cnt_m[i] >= TH3, cnt_m[i] >= TH2, cnt_m[i] >= TH1};
      if (a[i] && !d[i]) begin
        if (cnt_m[i] == CMAX) ovf_m[i] = 1'b1;
        else cnt_m[i]++;
      end else if (d[i] && !a[i] && cnt_m[i] > 0) cnt_m[i]--;
    end
    if (gnt < 0) begin
      if (e != 0) begin
        gnt = lowest_idx(e);
        rem = HOLD;
        pend_m |= e & ~(4'b0001 << gnt);
      end
    end else if (e[gnt]) begin
      rem = HOLD;
      pend_m |= e & ~(4'b0001 << gnt);
    end else begin
      pend_m |= e;
      rem--;
      if (rem == 0) begin
        n = lowest_idx(pend_m);
        if (n >= 0) begin gnt = n; pend_m[n] = 1'b0; rem = HOLD; end
        else gnt = -1;
      end
    end
  endtask

  function automatic void compare(input string tag, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got lvl=%h ss=%b ovf=%b busy=%b, want lvl=%h ss=%b ovf=%b busy=%b",
               tag, got.lvl, got.ss, got.ovf, got.busy, want.lvl, want.ss, want.ovf, want.busy);
    end
  endfunction

  task automatic step(input bit [3:0] a, input bit [3:0] d, input bit [3:0] e);
    @(negedge clock);
    clear_n = 1'b1;
    bus.arr = a; bus.dep = d; bus.emg_req = e;
    model_edge(a, d, e);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0, 4'b0, 4'b0);
  endtask

  // Asserted half a cycle after an edge, so the outputs must clear without one.
  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    bus.arr = '0; bus.dep = '0; bus.emg_req = '0;
    model_reset();
    #1 compare("async_reset", sample(), model_obs());
    exp_q.push_back(model_obs());
  endtask

  // Monitor
  initial begin
    obs_t want;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        compare($sformatf("cycle@%0t", $time), sample(), want);
      end
    end
  end

  initial begin
    bus.arr = '0; bus.dep = '0; bus.emg_req = '0;
    clear_n = 1'b0;
    model_reset();
    #2 compare("reset_state", sample(), model_obs());

    // Road a: cross TH1, then fall back under it.
    repeat (4) step(4'b0001, 4'b0000, 4'b0000);
    idle(2);
    step(4'b0000, 4'b0001, 4'b0000);
    idle(3);

    // Road b: saturate, overflow, drain to zero.
    repeat (70) step(4'b0010, 4'b0000, 4'b0000);
    repeat (70) step(4'b0000, 4'b0010, 4'b0000);
    idle(2);

    // Road c: simultaneous arrival and departure at count 5.
    repeat (5) step(4'b0100, 4'b0000, 4'b0000);
    repeat (10) step(4'b0100, 4'b0100, 4'b0000);
    idle(2);

    // Two requests in one cycle: ss1 then ss3 back to back.
    step(4'b0000, 4'b0000, 4'b0101);
    idle(2 * HOLD + 4);

    // Retrigger ss2 at timer == 3, then ss4 requested during the hold.
    step(4'b0000, 4'b0000, 4'b0010);
    for (int k = 0; k < 40 && !(gnt == 1 && rem == 4); k++) idle(1);
    step(4'b0000, 4'b0000, 4'b0010);
    idle(5);
    step(4'b0000, 4'b0000, 4'b1000);
    idle(2 * HOLD + 4);

    // Reset mid-hold with counters non-zero, then one arrival on road d.
    repeat (6) step(4'b1111, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0001);
    idle(5);
    do_reset();
    step(4'b1000, 4'b0000, 4'b0000);
    idle(3);

    // Random traffic with sparse emergency requests.
    for (int k = 0; k < 800; k++) begin
      bit [3:0] a, d, e;
      a = 4'($urandom);
      d = 4'($urandom) & 4'($urandom);
      if (k >= 400) a = a | 4'($urandom);
      for (int b = 0; b < 4; b++) e[b] = ($urandom_range(0, 24) == 0);
      step(a, d, e);
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
